// File: rtl/level_fifo.sv
// level_fifo: synchronous first-word fall-through FIFO with a registered
// occupancy counter and level-decoded status flags. A write that meets a
// read on an empty FIFO tunnels straight through to rd_data_o without
// touching storage.
//
// Optional feature macro: LEVEL_FIFO_ERR_FLAGS_EN
//   defined   -> sticky overflow_o / underflow_o flags, cleared by err_clr_i
//   undefined -> both flags tied low, err_clr_i ignored
module level_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_THR  = DEPTH - 1,
  parameter int AEMPTY_THR = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       wr_en_i,
  input  logic [WIDTH-1:0]           wr_data_i,
  input  logic                       rd_en_i,
  output logic [WIDTH-1:0]           rd_data_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       almost_empty_o,
  output logic                       almost_full_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  input  logic                       err_clr_i,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [LW-1:0] lvl_t;

  // Refuse to build with thresholds or sizes that make the flags meaningless.
  generate
    if (WIDTH < 1 || DEPTH < 1 ||
        AFULL_THR < 1 || AFULL_THR > DEPTH ||
        AEMPTY_THR < 0 || AEMPTY_THR > DEPTH - 1) begin : g_bad_params
      $error("level_fifo: WIDTH/DEPTH/AFULL_THR/AEMPTY_THR out of range");
    end
  endgenerate

  logic [WIDTH-1:0] mem_q [DEPTH];
  ptr_t             wr_ptr_q, rd_ptr_q;
  lvl_t             level_q;
  logic             tunnel, wr_acc, rd_acc;

  // Pointers wrap explicitly at DEPTH-1 so non-power-of-two depths work.
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  // Status flags are pure decodes of the registered level.
  assign level_o        = level_q;
  assign empty_o        = (level_q == '0);
  assign full_o         = (level_q == lvl_t'(DEPTH));
  assign almost_empty_o = (level_q <= lvl_t'(AEMPTY_THR));
  assign almost_full_o  = (level_q >= lvl_t'(AFULL_THR));

  // Tunnel is gated by reset so rd_data_o reads zero throughout reset.
  assign tunnel = wr_en_i & rd_en_i & empty_o & rst_ni;
  assign wr_acc = wr_en_i & (~full_o | rd_en_i) & ~tunnel;
  assign rd_acc = rd_en_i & ~empty_o;

  // Storage write port.
  // NOTE: the data array has no reset; validity is tracked solely by the
  // level counter, so clearing the entries would only add reset fan-out.
  always_ff @(posedge clk_i) begin
    if (wr_acc) mem_q[wr_ptr_q] <= wr_data_i;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_acc) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (rd_acc) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (wr_acc && !rd_acc)      level_q <= level_q + lvl_t'(1);
      else if (!wr_acc && rd_acc) level_q <= level_q - lvl_t'(1);
    end
  end

  // Head word: stored entry, tunnelled write data, or zero.
  // NOTE: the default assignment first keeps this block free of latches.
  always_comb begin
    rd_data_o = '0;
    if (!empty_o)    rd_data_o = mem_q[rd_ptr_q];
    else if (tunnel) rd_data_o = wr_data_i;
  end

`ifdef LEVEL_FIFO_ERR_FLAGS_EN
  logic ovf_q, udf_q;
  logic ovf_set, udf_set;

  assign ovf_set = wr_en_i & full_o & ~rd_en_i;
  assign udf_set = rd_en_i & empty_o & ~wr_en_i;

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ovf_set)        ovf_q <= 1'b1;
      else if (err_clr_i) ovf_q <= 1'b0;
      if (udf_set)        udf_q <= 1'b1;
      else if (err_clr_i) udf_q <= 1'b0;
    end
  end

  assign overflow_o  = ovf_q;
  assign underflow_o = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign overflow_o     = 1'b0;
  assign underflow_o    = 1'b0;
`endif

endmodule

// File: tb/tb_level_fifo.sv
// tb_level_fifo: scoreboard bench for level_fifo. Stimulus pushes expected
// observations into a queue; a monitor on the falling clock edge pops and
// compares them against the DUT outputs. DUT 0 is DEPTH=5, DUT 1 is DEPTH=1.
module tb_level_fifo;

`ifdef LEVEL_FIFO_ERR_FLAGS_EN
  localparam int FLAG_ON = 1;
`else
  localparam int FLAG_ON = 0;
`endif

  typedef enum int {S_DATA, S_LEVEL, S_EMPTY, S_FULL, S_AE, S_AF, S_OVF, S_UDF} sig_e;
  typedef struct {
    string name;
    int    dut;
    sig_e  sig;
    int    exp;
  } exp_t;

  logic clk_i = 1'b0;
  logic rst_ni;

  logic       a_wr, a_rd, a_clr, a_empty, a_full, a_ae, a_af, a_ovf, a_udf;
  logic [7:0] a_wd, a_rdata;
  logic [2:0] a_level;

  logic       b_wr, b_rd, b_clr, b_empty, b_full, b_ae, b_af, b_ovf, b_udf;
  logic [7:0] b_wd, b_rdata;
  logic [0:0] b_level;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  level_fifo #(.WIDTH(8), .DEPTH(5), .AFULL_THR(4), .AEMPTY_THR(1)) u_dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(a_wr), .wr_data_i(a_wd),
    .rd_en_i(a_rd), .rd_data_o(a_rdata), .empty_o(a_empty), .full_o(a_full),
    .almost_empty_o(a_ae), .almost_full_o(a_af), .level_o(a_level),
    .err_clr_i(a_clr), .overflow_o(a_ovf), .underflow_o(a_udf)
  );

  level_fifo #(.WIDTH(8), .DEPTH(1), .AFULL_THR(1), .AEMPTY_THR(0)) u_dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(b_wr), .wr_data_i(b_wd),
    .rd_en_i(b_rd), .rd_data_o(b_rdata), .empty_o(b_empty), .full_o(b_full),
    .almost_empty_o(b_ae), .almost_full_o(b_af), .level_o(b_level),
    .err_clr_i(b_clr), .overflow_o(b_ovf), .underflow_o(b_udf)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int actual(input int dut, input sig_e s);
    if (dut == 0) begin
      case (s)
        S_DATA:  return int'(a_rdata);
        S_LEVEL: return int'(a_level);
        S_EMPTY: return int'(a_empty);
        S_FULL:  return int'(a_full);
        S_AE:    return int'(a_ae);
        S_AF:    return int'(a_af);
        S_OVF:   return int'(a_ovf);
        default: return int'(a_udf);
      endcase
    end else begin
      case (s)
        S_DATA:  return int'(b_rdata);
        S_LEVEL: return int'(b_level);
        S_EMPTY: return int'(b_empty);
        S_FULL:  return int'(b_full);
        S_AE:    return int'(b_ae);
        S_AF:    return int'(b_af);
        S_OVF:   return int'(b_ovf);
        default: return int'(b_udf);
      endcase
    end
  endfunction

  // Monitor: compare every queued expectation against the settled outputs.
  always @(negedge clk_i) begin
    exp_t e;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check(e.name, actual(e.dut, e.sig), e.exp);
    end
  end

  task automatic ex(input int dut, input sig_e s, input int v, input string n);
    exp_t e;
    e.name = n; e.dut = dut; e.sig = s; e.exp = v;
    sb.push_back(e);
  endtask

  task automatic idle_inputs();
    a_wr = 0; a_rd = 0; a_clr = 0; a_wd = '0;
    b_wr = 0; b_rd = 0; b_clr = 0; b_wd = '0;
  endtask

  // Apply an operation just after a rising edge; it takes effect at the next.
  task automatic drive(input int dut, input logic wr, input logic [7:0] wd,
                       input logic rd, input logic clr);
    @(posedge clk_i); #1;
    if (dut == 0) begin a_wr = wr; a_wd = wd; a_rd = rd; a_clr = clr; end
    else          begin b_wr = wr; b_wd = wd; b_rd = rd; b_clr = clr; end
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    #1;
    ex(0, S_LEVEL, 0, "rst_level"); ex(0, S_EMPTY, 1, "rst_empty");
    ex(0, S_FULL, 0, "rst_full");   ex(0, S_AE, 1, "rst_ae");
    ex(0, S_AF, 0, "rst_af");       ex(0, S_DATA, 0, "rst_data");
    ex(0, S_OVF, 0, "rst_ovf");     ex(0, S_UDF, 0, "rst_udf");
    @(negedge clk_i); #1;
    rst_ni = 1'b1;

    // Fill 0x11..0x15 and watch the level decodes move.
    for (int i = 1; i <= 5; i++) begin
      drive(0, 1, 8'(8'h10 + i), 0, 0);
      tick();
      ex(0, S_LEVEL, i, $sformatf("fill_level_%0d", i));
      ex(0, S_AE, (i <= 1) ? 1 : 0, $sformatf("fill_ae_%0d", i));
      ex(0, S_AF, (i >= 4) ? 1 : 0, $sformatf("fill_af_%0d", i));
      ex(0, S_FULL, (i == 5) ? 1 : 0, $sformatf("fill_full_%0d", i));
      ex(0, S_DATA, 'h11, $sformatf("fill_head_%0d", i));
    end

    // Write into a full FIFO is dropped.
    drive(0, 1, 8'h66, 0, 0); tick();
    ex(0, S_LEVEL, 5, "ovf_level"); ex(0, S_DATA, 'h11, "ovf_head");
    ex(0, S_OVF, FLAG_ON, "ovf_set");
    drive(0, 0, 8'h00, 0, 1); tick();
    ex(0, S_OVF, 0, "ovf_clr");
    drive(0, 1, 8'h66, 0, 1); tick();
    ex(0, S_OVF, FLAG_ON, "ovf_set_wins");
    drive(0, 0, 8'h00, 0, 1); tick();
    ex(0, S_OVF, 0, "ovf_clr2");

    // Simultaneous write and read while full.
    drive(0, 1, 8'h77, 1, 0); tick();
    ex(0, S_LEVEL, 5, "wr_rd_full_level"); ex(0, S_FULL, 1, "wr_rd_full_full");
    ex(0, S_DATA, 'h12, "wr_rd_full_head");

    // Drain across the pointer wrap.
    begin
      logic [7:0] seq [5];
      seq[0] = 8'h12; seq[1] = 8'h13; seq[2] = 8'h14; seq[3] = 8'h15; seq[4] = 8'h77;
      for (int i = 0; i < 5; i++) begin
        drive(0, 0, 8'h00, 1, 0);
        ex(0, S_DATA, int'(seq[i]), $sformatf("drain_%0d", i));
        tick();
      end
    end
    ex(0, S_EMPTY, 1, "drain_empty"); ex(0, S_LEVEL, 0, "drain_level");
    ex(0, S_DATA, 0, "drain_data_zero");

    // Tunnel through an empty FIFO.
    drive(0, 1, 8'hA5, 1, 0);
    ex(0, S_DATA, 'hA5, "tunnel_data"); ex(0, S_EMPTY, 1, "tunnel_empty_now");
    tick();
    ex(0, S_LEVEL, 0, "tunnel_level"); ex(0, S_EMPTY, 1, "tunnel_empty_after");
    ex(0, S_UDF, 0, "tunnel_no_udf");

    // Read from empty is ignored.
    drive(0, 0, 8'h00, 1, 0); tick();
    ex(0, S_UDF, FLAG_ON, "udf_set"); ex(0, S_LEVEL, 0, "udf_level");
    drive(0, 0, 8'h00, 0, 1); tick();
    ex(0, S_UDF, 0, "udf_clr");

    // Asynchronous reset with three entries held.
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 8'(8'h21 + i), 0, 0); tick();
    end
    ex(0, S_LEVEL, 3, "pre_rst_level");
    @(negedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    ex(0, S_LEVEL, 0, "arst_level"); ex(0, S_EMPTY, 1, "arst_empty");
    ex(0, S_FULL, 0, "arst_full");   ex(0, S_AE, 1, "arst_ae");
    ex(0, S_AF, 0, "arst_af");       ex(0, S_DATA, 0, "arst_data");
    @(negedge clk_i); #1;
    rst_ni = 1'b1;
    drive(0, 1, 8'h3C, 0, 0); tick();
    ex(0, S_DATA, 'h3C, "post_rst_data"); ex(0, S_LEVEL, 1, "post_rst_level");
    ex(0, S_EMPTY, 0, "post_rst_empty");

    // DEPTH=1 instance.
    drive(1, 1, 8'h01, 0, 0); tick();
    ex(1, S_FULL, 1, "d1_full"); ex(1, S_EMPTY, 0, "d1_not_empty");
    ex(1, S_LEVEL, 1, "d1_level"); ex(1, S_DATA, 'h01, "d1_head");
    drive(1, 1, 8'h02, 0, 0); tick();
    ex(1, S_LEVEL, 1, "d1_drop_level"); ex(1, S_DATA, 'h01, "d1_drop_head");
    ex(1, S_OVF, FLAG_ON, "d1_ovf");
    drive(1, 0, 8'h00, 1, 0);
    ex(1, S_DATA, 'h01, "d1_read_data");
    tick();
    ex(1, S_EMPTY, 1, "d1_empty"); ex(1, S_FULL, 0, "d1_not_full");
    ex(1, S_LEVEL, 0, "d1_level0"); ex(1, S_DATA, 0, "d1_data_zero");

    @(negedge clk_i); #1;
    @(negedge clk_i); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
